// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared constants for the programmable counter.
//   Terminal-behaviour mode encodings and default widths.
package prog_counter_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11   // behaves as wrap
  } mode_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// prog_counter_prescaler: divides enabled cycles by div+1.
//   clk      - clock
//   rst_n    - async active-low reset
//   en       - advance the prescaler this cycle
//   sync_clr - restart the prescaler (clr or load on the counter)
//   div      - divisor minus one
//   tick     - high on the enabled cycle where the prescaler equals div
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // A restart cycle never produces a tick, so load/clr never count as progress.
  assign tick = en && !sync_clr && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == div) cnt <= '0;
      else            cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter with wrap, saturate and one-shot
// terminal behaviour.
//   clk, rst_n       - clock, async active-low reset
//   en               - count enable (gates the prescaler)
//   clr, load        - synchronous clear / load strobe (clr has priority)
//   load_val         - value loaded into count
//   limit            - up-count terminal value, down-count reload value
//   dir              - 1 = up, 0 = down
//   mode             - 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   div              - prescale divisor minus one
//   count            - registered count
//   tc               - one-cycle terminal-count pulse
//   ovf              - sticky wrap flag
//   done             - one-shot finished flag
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  done
);

  logic tick;
  logic terminal;

  prog_counter_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | load),
    .div      (div),
    .tick     (tick)
  );

  // ">=" rather than "==" so lowering limit below the running count still terminates.
  assign terminal = dir ? (count >= limit) : (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (tick && !done) begin
      if (terminal) begin
        tc <= 1'b1;
        case (mode)
          MODE_SAT: ;
          MODE_ONESHOT: done <= 1'b1;
          default: begin
            count <= dir ? '0 : limit;
            ovf   <= 1'b1;
          end
        endcase
      end else begin
        tc    <= 1'b0;
        count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed self-checking bench for prog_counter
// (WIDTH=8, PRESCALE_W=4).
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] limit = '0;
  logic       dir = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] div = '0;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  prog_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .dir(dir), .mode(mode), .div(div),
    .count(count), .tc(tc), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  // One clock, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b0; load_val = v; load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    if ({count, tc, ovf, done} !== 11'd0) begin
      $display("FAIL reset count=%0h tc=%b ovf=%b done=%b exp all 0", count, tc, ovf, done);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_c;
    do_clr();
    mode = 2'b00; dir = 1'b1; limit = 8'd5; div = 4'd0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_c = (i == 6) ? 8'd0 : 8'(i);
      if (count !== exp_c || tc !== (i == 6)) begin
        $display("FAIL wrap_up step=%0d count=%0d tc=%b exp count=%0d tc=%b", i, count, tc, exp_c, (i == 6));
        n_fail++;
      end
      n_tests++;
    end
    en = 1'b0;
    step();
    if (ovf !== 1'b1 || tc !== 1'b0) begin
      $display("FAIL wrap_ovf ovf=%b tc=%b exp ovf=1 tc=0", ovf, tc);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_prescale();
    logic [7:0] exp_c;
    do_clr();
    div = 4'd3; limit = 8'd255; dir = 1'b1; mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_c = 8'((i + 1) / 4);
      if (count !== exp_c) begin
        $display("FAIL prescale_en step=%0d count=%0d exp=%0d", i, count, exp_c);
        n_fail++;
      end
      n_tests++;
    end
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      step();
      exp_c = 8'(3 + (i + 2) / 8);
      if (count !== exp_c) begin
        $display("FAIL prescale_toggle step=%0d count=%0d exp=%0d", i, count, exp_c);
        n_fail++;
      end
      n_tests++;
    end
    en = 1'b0;
  endtask

  task automatic test_down();
    logic [7:0] exp_w [3] = '{8'd1, 8'd0, 8'd9};
    logic [7:0] exp_s [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
    logic       tcs_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    // wrap
    do_clr();
    do_load(8'd2);
    if (count !== 8'd2) begin
      $display("FAIL down_load count=%0d exp=2", count);
      n_fail++;
    end
    n_tests++;
    dir = 1'b0; mode = 2'b00; limit = 8'd9; div = 4'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (count !== exp_w[i] || tc !== (i == 2)) begin
        $display("FAIL down_wrap step=%0d count=%0d tc=%b exp count=%0d tc=%b", i, count, tc, exp_w[i], (i == 2));
        n_fail++;
      end
      n_tests++;
    end
    if (ovf !== 1'b1) begin
      $display("FAIL down_wrap_ovf ovf=%b exp=1", ovf);
      n_fail++;
    end
    n_tests++;
    // saturate
    do_clr();
    do_load(8'd2);
    dir = 1'b0; mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (count !== exp_s[i] || tc !== tcs_s[i]) begin
        $display("FAIL down_sat step=%0d count=%0d tc=%b exp count=%0d tc=%b", i, count, tc, exp_s[i], tcs_s[i]);
        n_fail++;
      end
      n_tests++;
    end
    if (ovf !== 1'b0) begin
      $display("FAIL down_sat_ovf ovf=%b exp=0", ovf);
      n_fail++;
    end
    n_tests++;
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    int tc_seen = 0;
    do_clr();
    mode = 2'b10; dir = 1'b1; limit = 8'd3; div = 4'd0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tc === 1'b1) tc_seen++;
      if (count !== exp_c[i] || done !== (i >= 3)) begin
        $display("FAIL oneshot step=%0d count=%0d done=%b exp count=%0d done=%b", i, count, done, exp_c[i], (i >= 3));
        n_fail++;
      end
      n_tests++;
    end
    if (tc_seen != 1) begin
      $display("FAIL oneshot_tc pulses=%0d exp=1", tc_seen);
      n_fail++;
    end
    n_tests++;
    do_load(8'd1);
    if (count !== 8'd1 || done !== 1'b0) begin
      $display("FAIL oneshot_load count=%0d done=%b exp count=1 done=0", count, done);
      n_fail++;
    end
    n_tests++;
    en = 1'b1;
    step();
    if (count !== 8'd2) begin
      $display("FAIL oneshot_resume count=%0d exp=2", count);
      n_fail++;
    end
    n_tests++;
    en = 1'b0;
  endtask

  task automatic test_priority();
    logic [7:0] exp_c;
    en = 1'b0; mode = 2'b00; dir = 1'b1; limit = 8'd255;
    load_val = 8'hAA; clr = 1'b1; load = 1'b1;
    step();
    clr = 1'b0; load = 1'b0;
    if (count !== 8'h00) begin
      $display("FAIL prio_clr_load count=%0h exp=0", count);
      n_fail++;
    end
    n_tests++;
    // Build some prescaler progress, then load with en held high.
    div = 4'd3; en = 1'b1;
    step(); step();
    load = 1'b1;
    step();
    load = 1'b0;
    if (count !== 8'hAA) begin
      $display("FAIL prio_load_en count=%0h exp=aa", count);
      n_fail++;
    end
    n_tests++;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_c = (i == 4) ? 8'hAB : 8'hAA;
      if (count !== exp_c) begin
        $display("FAIL prio_restart step=%0d count=%0h exp=%0h", i, count, exp_c);
        n_fail++;
      end
      n_tests++;
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clr();
    mode = 2'b00; dir = 1'b1; limit = 8'd0; div = 4'd0; en = 1'b1;
    step();
    if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      $display("FAIL limit0 count=%0d tc=%b ovf=%b exp 0 1 1", count, tc, ovf);
      n_fail++;
    end
    n_tests++;
    do_load(8'h37);
    limit = 8'd255; div = 4'd2; en = 1'b1;
    step(); step();
    en = 1'b0;
    if (count !== 8'h37 || ovf !== 1'b1) begin
      $display("FAIL premid count=%0h ovf=%b exp 37 1", count, ovf);
      n_fail++;
    end
    n_tests++;
    #2 rst_n = 1'b0;
    #1;
    if ({count, tc, ovf, done} !== 11'd0) begin
      $display("FAIL reset_mid count=%0h tc=%b ovf=%b done=%b exp all 0", count, tc, ovf, done);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (count !== ((i == 3) ? 8'd1 : 8'd0)) begin
        $display("FAIL first_tick step=%0d count=%0d exp=%0d", i, count, (i == 3));
        n_fail++;
      end
      n_tests++;
    end
    do_load(8'd50);
    limit = 8'd200; div = 4'd0; mode = 2'b00; dir = 1'b1;
    limit = 8'd10; en = 1'b1;
    step();
    if (count !== 8'd0 || tc !== 1'b1) begin
      $display("FAIL limit_lowered count=%0d tc=%b exp count=0 tc=1", count, tc);
      n_fail++;
    end
    n_tests++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_prescale();
    test_down();
    test_oneshot();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
